// File: rtl/inst_fetch_unit_pkg.sv
// ============================================================================
// Module : inst_fetch_unit_pkg
// Brief  : Shared opcode constant and fetch FSM encoding for the fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package inst_fetch_unit_pkg;

   localparam logic [31:0] c_INST_NOOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_RUN   = 2'd1,
      FETCH_DRAIN = 2'd2,
      FETCH_DONE  = 2'd3
   } fetchState_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module : fetch_fifo
// Brief  : Synchronous prefetch FIFO with occupancy count and synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
   parameter int WIDTH = 42,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         headData,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W:0]   r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign empty    = (r_count == '0);
   assign full     = (r_count == (PTR_W+1)'(DEPTH));
   assign count    = r_count;
   assign headData = r_mem[r_rdPtr];
   assign w_doPop  = pop && !empty;
   // A pop frees the head slot in the same edge, so a full FIFO may still accept.
   assign w_doPush = push && (!full || w_doPop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (clear) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
         if (w_doPush && !w_doPop)      r_count <= r_count + (PTR_W+1)'(1);
         else if (!w_doPush && w_doPop) r_count <= r_count - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_doPush && !clear) r_mem[r_wrPtr] <= pushData;
   end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module : inst_fetch_unit
// Brief  : Sequences a PC over synchronous instruction memory and streams words
//          to decode, with stall, redirect flush and completion signalling.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   prog_len,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   output logic [31:0]       instruction,
   output logic              inst_valid,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              busy,
   output logic              done
);
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int ENTRY_W = 32 + ADDR_W;

   fetchState_t         r_state;
   logic [ADDR_W:0]     r_pc;
   logic [ADDR_W:0]     r_len;
   logic                r_inflight;
   logic [ADDR_W-1:0]   r_inflightAddr;

   logic [CNT_W-1:0]    w_fifoCount;
   logic                w_fifoFull;
   logic                w_fifoEmpty;
   logic [ENTRY_W-1:0]  w_fifoHead;
   logic                w_flushAct;
   logic                w_credit;
   logic                w_retValid;
   logic                w_bypass;
   logic                w_pop;
   logic                w_push;
   logic                w_lastReq;
   logic                w_drained;

   assign w_flushAct = flush && (r_state == FETCH_RUN || r_state == FETCH_DRAIN);
   assign w_credit   = (w_fifoCount + CNT_W'(r_inflight)) < CNT_W'(FIFO_DEPTH);
   assign imem_en    = (r_state == FETCH_RUN) && (r_pc < r_len) && w_credit && !flush;
   assign imem_addr  = r_pc[ADDR_W-1:0];

   // Requests are never issued during a flush, so the only word that can be
   // stale is the one returning in the flush cycle itself.
   assign w_retValid = r_inflight && !flush;
   assign w_bypass   = w_retValid && !stall && w_fifoEmpty;
   assign w_pop      = !flush && !stall && !w_fifoEmpty;
   assign w_push     = w_retValid && !w_bypass && (!w_fifoFull || w_pop);
   assign w_lastReq  = imem_en && ((r_pc + (ADDR_W+1)'(1)) == r_len);
   assign w_drained  = w_fifoEmpty && !r_inflight && !stall;

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (w_flushAct),
      .push     (w_push),
      .pushData ({imem_rdata, r_inflightAddr}),
      .pop      (w_pop),
      .headData (w_fifoHead),
      .count    (w_fifoCount),
      .full     (w_fifoFull),
      .empty    (w_fifoEmpty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= FETCH_IDLE;
         r_pc           <= '0;
         r_len          <= '0;
         r_inflight     <= 1'b0;
         r_inflightAddr <= '0;
         instruction    <= c_INST_NOOP;
         inst_valid     <= 1'b0;
         inst_pc        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         r_inflight     <= imem_en;
         r_inflightAddr <= imem_addr;

         // Returning data goes straight to the output when nothing is queued ahead of it.
         if (flush) begin
            instruction <= c_INST_NOOP;
            inst_valid  <= 1'b0;
         end else if (!stall) begin
            if (!w_fifoEmpty) begin
               {instruction, inst_pc} <= w_fifoHead;
               inst_valid             <= 1'b1;
            end else if (w_bypass) begin
               instruction <= imem_rdata;
               inst_pc     <= r_inflightAddr;
               inst_valid  <= 1'b1;
            end else begin
               instruction <= c_INST_NOOP;
               inst_valid  <= 1'b0;
            end
         end

         if (w_flushAct) begin
            r_pc    <= {1'b0, flush_pc};
            r_state <= ({1'b0, flush_pc} < r_len) ? FETCH_RUN : FETCH_DRAIN;
         end else begin
            case (r_state)
               FETCH_IDLE, FETCH_DONE: begin
                  if (start) begin
                     r_len <= prog_len;
                     r_pc  <= '0;
                     if (prog_len == '0) begin
                        r_state <= FETCH_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                     end else begin
                        r_state <= FETCH_RUN;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                     end
                  end
               end
               FETCH_RUN: begin
                  if (imem_en) begin
                     r_pc <= r_pc + (ADDR_W+1)'(1);
                     if (w_lastReq) r_state <= FETCH_DRAIN;
                  end
               end
               FETCH_DRAIN: begin
                  if (w_drained) begin
                     r_state <= FETCH_DONE;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                  end
               end
               default: r_state <= FETCH_IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// Module : tb_inst_fetch_unit
// Brief  : Scoreboard bench for inst_fetch_unit (ADDR_W=10 and ADDR_W=3 instances).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_unit;

   typedef struct {
      logic [31:0] word;
      logic [9:0]  pc;
   } sbEntry_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [10:0] prog_len;
   logic        imem_en;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        flush;
   logic [9:0]  flush_pc;
   logic [31:0] instruction;
   logic        inst_valid;
   logic [9:0]  inst_pc;
   logic        busy;
   logic        done;

   logic        start3;
   logic [3:0]  progLen3;
   logic        imemEn3;
   logic [2:0]  imemAddr3;
   logic [31:0] imemRdata3;
   logic [31:0] instr3;
   logic        valid3;
   logic [2:0]  instPc3;
   logic        busy3;
   logic        done3;

   logic [31:0] mem  [1024];
   logic [31:0] mem3 [8];
   sbEntry_t    sbQ[$];
   int          vecCount  = 0;
   int          missCount = 0;
   int          enTotal   = 0;
   int          enTotal3  = 0;
   int          k3        = 0;
   logic        prevValid = 1'b0;
   logic [31:0] prevInstr = 32'h0;

   always #5 clk = ~clk;

   inst_fetch_unit #(.ADDR_W(10), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .stall(stall), .flush(flush), .flush_pc(flush_pc),
      .instruction(instruction), .inst_valid(inst_valid), .inst_pc(inst_pc),
      .busy(busy), .done(done)
   );

   inst_fetch_unit #(.ADDR_W(3), .FIFO_DEPTH(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .prog_len(progLen3),
      .imem_en(imemEn3), .imem_addr(imemAddr3), .imem_rdata(imemRdata3),
      .stall(1'b0), .flush(1'b0), .flush_pc(3'd0),
      .instruction(instr3), .inst_valid(valid3), .inst_pc(instPc3),
      .busy(busy3), .done(done3)
   );

   // Synchronous instruction memories: data valid one cycle after enable.
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem[imem_addr];
      if (imemEn3) imemRdata3 <= mem3[imemAddr3];
      enTotal  <= enTotal + int'(imem_en);
      enTotal3 <= enTotal3 + int'(imemEn3);
   end

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vecCount++;
      if (got !== exp) begin
         missCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic monitor();
      sbEntry_t e;
      if (stall && !flush && prevValid) begin
         checkEq("holdWord", instruction, prevInstr);
         checkEq("holdValid", inst_valid, 1'b1);
      end else if (inst_valid) begin
         if (sbQ.size() == 0) begin
            checkEq("sbUnderflow", sbQ.size(), 1);
         end else begin
            e = sbQ.pop_front();
            checkEq("word", instruction, e.word);
            checkEq("pc", inst_pc, e.pc);
         end
      end
      prevValid = inst_valid;
      prevInstr = instruction;
      if (valid3) begin
         if (k3 >= 8) begin
            checkEq("extraWord3", k3, 7);
         end else begin
            checkEq("word3", instr3, mem3[k3]);
            checkEq("pc3", instPc3, k3);
         end
         k3++;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      monitor();
   endtask

   task automatic startProg(input int len);
      sbQ.delete();
      for (int i = 0; i < len; i++) sbQ.push_back('{mem[i], 10'(i)});
      prog_len = 11'(len);
      start    = 1'b1;
      cycle();
      start    = 1'b0;
   endtask

   task automatic waitDone(input int n0, output int n);
      n = n0;
      while (!done && n < 200) begin
         cycle();
         n++;
      end
      if (!done) checkEq("doneTimeout", done, 1'b1);
   endtask

   initial begin
      int n;
      int enStart;
      for (int i = 0; i < 1024; i++) mem[i] = (i < 5) ? 32'h0800_0001 + i : 32'hF000_0000 + i;
      for (int i = 0; i < 8; i++) mem3[i] = 32'hA000_0000 + i;
      rst_n = 1'b0; start = 1'b0; prog_len = '0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
      start3 = 1'b0; progLen3 = '0;
      #12;
      checkEq("rstInstr", instruction, 32'h0);
      checkEq("rstValid", inst_valid, 1'b0);
      checkEq("rstPc", inst_pc, 10'h0);
      checkEq("rstBusyDone", {busy, done, imem_en}, 3'b000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle();

      // Plain run: first word two cycles after start, done seven cycles after start
      enStart = enTotal;
      startProg(5);
      checkEq("runBusy", busy, 1'b1);
      checkEq("firstReq", {imem_en, imem_addr}, {1'b1, 10'd0});
      cycle(); cycle();
      checkEq("latency", inst_valid, 1'b1);
      waitDone(2, n);
      checkEq("doneCycle", n, 7);
      checkEq("doneNoop", {inst_valid, instruction}, 33'h0);
      checkEq("sbEmpty1", sbQ.size(), 0);
      checkEq("enables1", enTotal - enStart, 5);

      // Stall for three cycles while the second word is on the output
      enStart = enTotal;
      startProg(5);
      cycle(); cycle(); cycle();
      checkEq("stallWordPc", {inst_valid, inst_pc}, {1'b1, 10'd1});
      stall = 1'b1;
      cycle(); cycle();
      checkEq("creditHold", imem_en, 1'b0);
      cycle();
      stall = 1'b0;
      waitDone(6, n);
      checkEq("doneCycle2", n, 10);
      checkEq("sbEmpty2", sbQ.size(), 0);
      checkEq("enables2", enTotal - enStart, 5);

      // Redirect to address 1 while the third word is on the output
      startProg(5);
      cycle(); cycle(); cycle(); cycle();
      checkEq("flushWordPc", {inst_valid, inst_pc}, {1'b1, 10'd2});
      flush = 1'b1; flush_pc = 10'd1;
      sbQ.delete();
      for (int i = 1; i < 5; i++) sbQ.push_back('{mem[i], 10'(i)});
      cycle();
      checkEq("flushBubble", {inst_valid, instruction}, 33'h0);
      flush = 1'b0;
      waitDone(5, n);
      checkEq("sbEmpty3", sbQ.size(), 0);

      // Zero-length and single-word programs
      enStart = enTotal;
      startProg(0);
      checkEq("len0Done", {done, busy}, 2'b10);
      cycle();
      checkEq("len0Enables", enTotal - enStart, 0);
      enStart = enTotal;
      startProg(1);
      waitDone(0, n);
      checkEq("len1Enables", enTotal - enStart, 1);
      checkEq("sbEmpty4", sbQ.size(), 0);

      // Asynchronous reset with the prefetch FIFO full, then a clean restart
      stall = 1'b1;
      startProg(5);
      cycle(); cycle(); cycle(); cycle();
      #1 rst_n = 1'b0;
      #1;
      checkEq("midRstInstr", {inst_valid, instruction}, 33'h0);
      checkEq("midRstPc", inst_pc, 10'h0);
      checkEq("midRstCtl", {busy, done, imem_en}, 3'b000);
      stall = 1'b0;
      prevValid = 1'b0;
      sbQ.delete();
      cycle(); cycle();
      rst_n = 1'b1;
      enStart = enTotal;
      startProg(5);
      checkEq("restartReq", {imem_en, imem_addr}, {1'b1, 10'd0});
      waitDone(0, n);
      checkEq("doneCycle5", n, 7);
      checkEq("sbEmpty5", sbQ.size(), 0);
      checkEq("enables5", enTotal - enStart, 5);

      // Full memory sweep on the 3-bit address instance
      enStart = enTotal3;
      k3 = 0;
      progLen3 = 4'd8;
      start3 = 1'b1;
      cycle();
      start3 = 1'b0;
      n = 0;
      while (!done3 && n < 100) begin
         cycle();
         n++;
      end
      if (!done3) checkEq("done3Timeout", done3, 1'b1);
      checkEq("doneCycle3", n, 10);
      checkEq("words3", k3, 8);
      checkEq("enables3", enTotal3 - enStart, 8);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

`default_nettype wire
